// File: rtl/amstrad_cfg_pkg.sv
// Shared types and constants for the Amstrad gate-array/ROM-select configuration writer.
// Define CFG_WR_ROMSEL_EN to include the ROM-select write as a third item.
package amstrad_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RELEASE,
    ST_DONE
  } state_t;

  localparam logic [1:0] ITEM_RMR    = 2'd0;
  localparam logic [1:0] ITEM_MMR    = 2'd1;
  localparam logic [1:0] ITEM_ROMSEL = 2'd2;

`ifdef CFG_WR_ROMSEL_EN
  localparam int ITEM_COUNT = 3;
`else
  localparam int ITEM_COUNT = 2;
`endif

  localparam logic [1:0] ITEM_LAST = 2'(ITEM_COUNT - 1);

  // A15=0 selects the gate array, A13=0 selects ROM select; each address clears only one.
  localparam logic [15:0] IO_GA_ADDR     = 16'h7F00;
  localparam logic [15:0] IO_ROMSEL_ADDR = 16'hDF00;

  localparam logic [1:0] RMR_PFX = 2'b10;
  localparam logic [1:0] MMR_PFX = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/amstrad_cfg_timer.sv
// Loadable down-counter with a zero flag; times both the strobe-high and gap-low phases.
module amstrad_cfg_timer #(
  parameter int W = 3
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/amstrad_cfg_writer.sv
// Bus-master sequencer replaying RMR, MMR and (with CFG_WR_ROMSEL_EN) ROM-select I/O writes.
// Requests the bus, issues edge-qualified io_WR strobes, then hands the bus back.
module amstrad_cfg_writer
  import amstrad_cfg_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  rmr,
  input  logic [5:0]  mmr,
  input  logic [7:0]  rom_sel,
  input  logic        bus_ack,
  output logic        bus_req,
  output logic        io_WR,
  output logic [15:0] A,
  output logic [7:0]  D,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(max_int(PULSE_LEN, GAP_LEN)) + 1;

  state_t     state, state_nxt;
  logic [1:0] item, item_nxt;
  logic       abort_q, abort_set;
  logic [5:0] rmr_q, mmr_q;
  logic [7:0] rom_sel_q;

  logic          timer_load, timer_en, timer_zero;
  logic [CW-1:0] timer_val;

  amstrad_cfg_timer #(.W(CW)) u_timer (
    .CLK      (CLK),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .en       (timer_en),
    .zero     (timer_zero)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= ST_IDLE;
      item    <= ITEM_RMR;
      abort_q <= 1'b0;
    end else begin
      state <= state_nxt;
      item  <= item_nxt;
      if (state == ST_IDLE && start) abort_q <= 1'b0;
      else if (abort_set)            abort_q <= 1'b1;
    end
  end

  // NOTE: payload registers carry no reset; they are always written before any write cycle reads them.
  always_ff @(posedge CLK) begin
    if (state == ST_IDLE && start) begin
      rmr_q     <= rmr;
      mmr_q     <= mmr;
      rom_sel_q <= rom_sel;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    item_nxt   = item;
    timer_load = 1'b0;
    timer_val  = '0;
    abort_set  = 1'b0;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_REQ;
      ST_REQ: begin
        if (bus_ack) begin
          state_nxt = ST_SETUP;
          item_nxt  = ITEM_RMR;
        end
      end
      ST_SETUP: begin
        if (!bus_ack) begin
          state_nxt = ST_RELEASE;
          abort_set = 1'b1;
        end else begin
          state_nxt  = ST_STROBE;
          timer_load = 1'b1;
          timer_val  = CW'(PULSE_LEN - 1);
        end
      end
      ST_STROBE: begin
        if (!bus_ack) begin
          state_nxt = ST_RELEASE;
          abort_set = 1'b1;
        end else if (timer_zero) begin
          state_nxt  = ST_HOLD;
          timer_load = 1'b1;
          timer_val  = CW'(GAP_LEN - 1);
        end
      end
      ST_HOLD: begin
        if (!bus_ack) begin
          state_nxt = ST_RELEASE;
          abort_set = 1'b1;
        end else if (timer_zero) begin
          if (item == ITEM_LAST) begin
            state_nxt = ST_RELEASE;
          end else begin
            state_nxt = ST_SETUP;
            item_nxt  = item + 2'd1;
          end
        end
      end
      ST_RELEASE: if (!bus_ack) state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign timer_en = (state == ST_STROBE) || (state == ST_HOLD);

  logic        drive;
  logic [15:0] item_addr;
  logic [7:0]  item_data;

  always_comb begin
    item_addr = '0;
    item_data = '0;
    case (item)
      ITEM_RMR: begin
        item_addr = IO_GA_ADDR;
        item_data = {RMR_PFX, rmr_q};
      end
      ITEM_MMR: begin
        item_addr = IO_GA_ADDR;
        item_data = {MMR_PFX, mmr_q};
      end
`ifdef CFG_WR_ROMSEL_EN
      ITEM_ROMSEL: begin
        item_addr = IO_ROMSEL_ADDR;
        item_data = rom_sel_q;
      end
`endif
      default: ;
    endcase
  end

`ifndef CFG_WR_ROMSEL_EN
  logic unused_rom_sel;
  assign unused_rom_sel = ^rom_sel_q;
`endif

  assign drive   = (state == ST_SETUP) || (state == ST_STROBE) || (state == ST_HOLD);
  assign bus_req = drive || (state == ST_REQ);
  assign io_WR   = (state == ST_STROBE);
  assign A       = drive ? item_addr : 16'h0000;
  assign D       = drive ? item_data : 8'h00;
  assign busy    = (state != ST_IDLE) && (state != ST_DONE);
  assign done    = (state == ST_DONE);
  assign err     = (state == ST_DONE) && abort_q;

endmodule

// File: tb/tb_amstrad_cfg_writer.sv
// Scoreboard bench: expected writes/completions are queued at start, a negedge monitor pops and compares.
module tb_amstrad_cfg_writer;

  localparam int P  = 4;
  localparam int G  = 4;
`ifdef CFG_WR_ROMSEL_EN
  localparam int N_ITEMS = 3;
`else
  localparam int N_ITEMS = 2;
`endif
  localparam int EXP_LEN = N_ITEMS * (1 + P + G);

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  rmr = '0, mmr = '0;
  logic [7:0]  rom_sel = '0;
  logic        bus_ack, bus_req, io_WR, busy, done, err;
  logic [15:0] A;
  logic [7:0]  D;

  logic        start2 = 1'b0;
  logic        bus_ack2, bus_req2, io_WR2, busy2, done2, err2;
  logic [15:0] A2;
  logic [7:0]  D2;

  always #5 CLK = ~CLK;

  amstrad_cfg_writer #(.PULSE_LEN(P), .GAP_LEN(G)) dut (
    .CLK(CLK), .reset(reset), .start(start), .rmr(rmr), .mmr(mmr), .rom_sel(rom_sel),
    .bus_ack(bus_ack), .bus_req(bus_req), .io_WR(io_WR), .A(A), .D(D),
    .busy(busy), .done(done), .err(err)
  );

  amstrad_cfg_writer #(.PULSE_LEN(1), .GAP_LEN(1)) dut_fast (
    .CLK(CLK), .reset(reset), .start(start2), .rmr(rmr), .mmr(mmr), .rom_sel(rom_sel),
    .bus_ack(bus_ack2), .bus_req(bus_req2), .io_WR(io_WR2), .A(A2), .D(D2),
    .busy(busy2), .done(done2), .err(err2)
  );

  // CPU wrapper model: grants/releases the bus a few cycles after the request changes.
  logic [3:0] ack_hist = '0;
  logic       ack_hist2 = 1'b0;
  int         ack_dly = 2;
  logic       force_high = 1'b0, force_low = 1'b0;
  always @(negedge CLK) begin
    ack_hist  = {ack_hist[2:0], bus_req};
    ack_hist2 = bus_req2;
  end
  assign bus_ack  = force_high | (!force_low & ack_hist[ack_dly-1]);
  assign bus_ack2 = ack_hist2;

  int checks = 0, errors = 0;
  logic [23:0] exp_wr[$];
  bit          exp_done[$];
  bit          relaxed = 1'b0;
  int          df00_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one write per item in fixed order, then one completion.
  task automatic push_seq(input logic [5:0] r, input logic [5:0] m, input logic [7:0] s,
                          input int n_writes, input bit aborted);
    logic [23:0] items[3];
    items[0] = {16'h7F00, 2'b10, r};
    items[1] = {16'h7F00, 2'b11, m};
    items[2] = {16'hDF00, s};
    for (int i = 0; i < n_writes; i++) exp_wr.push_back(items[i]);
    exp_done.push_back(aborted);
  endtask

  // Monitor
  logic prev_wr = 1'b0, prev_a_nz = 1'b0, lo_active = 1'b0;
  int   hi_cnt = 0, lo_cnt = 0, seq_cnt = 0;
  always @(negedge CLK) begin
    if (reset) begin
      prev_wr = 1'b0; prev_a_nz = 1'b0; lo_active = 1'b0; seq_cnt = 0;
    end else begin
      if (A == 16'hDF00) df00_cnt++;
      if (io_WR && !prev_wr) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write got A=%h D=%h expected none", A, D);
        end else begin
          check("write", {8'h00, A, D}, {8'h00, exp_wr.pop_front()});
        end
        if (lo_active && !relaxed) check("gap_len", lo_cnt, G + 1);
        hi_cnt = 1; lo_active = 1'b0;
      end else if (io_WR) begin
        hi_cnt++;
      end else if (prev_wr) begin
        if (A != 0 && !relaxed) check("pulse_len", hi_cnt, P);
        lo_active = (A != 0); lo_cnt = 1;
      end else if (lo_active && A != 0) begin
        lo_cnt++;
      end
      if (A != 0) begin
        seq_cnt++;
      end else if (prev_a_nz) begin
        if (!relaxed) begin
          check("seq_len", seq_cnt, EXP_LEN);
          check("req_drop", bus_req, 0);
          if (lo_active) check("last_gap", lo_cnt, G);
        end
        seq_cnt = 0; lo_active = 1'b0;
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done got done=1 expected none");
        end else begin
          check("done_err", err, exp_done.pop_front());
        end
        check("busy_at_done", busy, 0);
      end else if (err) begin
        check("err_without_done", err, 0);
      end
      prev_wr = io_WR; prev_a_nz = (A != 0);
    end
  end

  task automatic pulse_start(input logic [5:0] r, input logic [5:0] m, input logic [7:0] s);
    @(negedge CLK);
    rmr = r; mmr = m; rom_sel = s; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge CLK);
    end
    if (!seen) check("done_timeout", 0, 1);
    repeat (4) @(negedge CLK);
  endtask

  task automatic wait_rises(input int n);
    logic pw = io_WR;
    int   seen = 0;
    for (int i = 0; i < 400 && seen < n; i++) begin
      @(negedge CLK);
      if (io_WR && !pw) seen++;
      pw = io_WR;
    end
    if (seen < n) check("rise_timeout", seen, n);
  endtask

  task automatic run_random(input int n);
    logic [5:0] r, m;
    logic [7:0] s;
    for (int k = 0; k < n; k++) begin
      r = 6'($urandom); m = 6'($urandom); s = 8'($urandom);
      ack_dly = $urandom_range(1, 3);
      push_seq(r, m, s, N_ITEMS, 1'b0);
      pulse_start(r, m, s);
      wait_done(200);
    end
  endtask

  initial begin
    int cnt;
    bit ended;
    repeat (3) @(negedge CLK);
    check("rst_bus_req", bus_req, 0);
    check("rst_io_wr", io_WR, 0);
    check("rst_a", A, 0);
    check("rst_d", D, 0);
    check("rst_busy_done_err", {busy, done, err}, 0);
    reset = 1'b0;

    // Directed full run
    ack_dly = 2;
    push_seq(6'h0D, 6'h02, 8'h07, N_ITEMS, 1'b0);
    pulse_start(6'h0D, 6'h02, 8'h07);
    check("busy_after_start", busy, 1);
    wait_done(200);

    run_random(6);

    // bus_ack already high when start arrives: REQ lasts one cycle
    ack_dly = 1;
    force_high = 1'b1;
    push_seq(6'h15, 6'h2A, 8'hC3, N_ITEMS, 1'b0);
    pulse_start(6'h15, 6'h2A, 8'hC3);
    check("req_cycle", {bus_req, (A == 16'h0)}, 2'b11);
    @(negedge CLK);
    check("setup_after_1_req", A, 16'h7F00);
    force_high = 1'b0;
    wait_done(200);

    // start while busy with changed inputs is ignored
    ack_dly = 2;
    push_seq(6'h01, 6'h3F, 8'h55, N_ITEMS, 1'b0);
    pulse_start(6'h01, 6'h3F, 8'h55);
    repeat (6) @(negedge CLK);
    pulse_start(6'h22, 6'h11, 8'hAA);
    repeat (12) @(negedge CLK);
    pulse_start(6'h33, 6'h0F, 8'h99);
    wait_done(200);

    // Abort: drop bus_ack during the second strobe
    relaxed = 1'b1;
    push_seq(6'h0A, 6'h05, 8'h3C, 2, 1'b1);
    pulse_start(6'h0A, 6'h05, 8'h3C);
    wait_rises(2);
    force_low = 1'b1;
    @(negedge CLK);
    check("abort_wr_low", io_WR, 0);
    check("abort_ad_zero", {A, D}, 0);
    wait_done(50);
    force_low = 1'b0;
    relaxed = 1'b0;
    repeat (4) @(negedge CLK);

    // Reset in the third HOLD cycle of item 1
    relaxed = 1'b1;
    push_seq(6'h1C, 6'h23, 8'h81, 2, 1'b0);
    pulse_start(6'h1C, 6'h23, 8'h81);
    wait_rises(2);
    cnt = 0;
    while (io_WR && cnt < 50) begin @(negedge CLK); cnt++; end
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    check("rst_mid_outputs", {bus_req, io_WR, A, D, busy, done, err}, 0);
    reset = 1'b0;
    if (exp_done.size() > 0) void'(exp_done.pop_back());
    repeat (20) @(negedge CLK);
    check("rst_no_pending_writes", exp_wr.size(), 0);
    relaxed = 1'b0;
    push_seq(6'h2E, 6'h19, 8'h44, N_ITEMS, 1'b0);
    pulse_start(6'h2E, 6'h19, 8'h44);
    wait_done(200);

    // PULSE_LEN=1, GAP_LEN=1 timing on the second instance
    @(negedge CLK);
    start2 = 1'b1;
    @(negedge CLK);
    start2 = 1'b0;
    cnt = 0; ended = 1'b0;
    for (int i = 0; i < 100 && !ended; i++) begin
      @(negedge CLK);
      if (A2 != 0) cnt++;
      else if (cnt > 0) begin
        ended = 1'b1;
        check("fast_req_drop", bus_req2, 0);
      end
    end
    check("fast_seq_len", cnt, N_ITEMS * 3);
    repeat (10) @(negedge CLK);
    check("fast_done_idle", {busy2, err2}, 0);

`ifndef CFG_WR_ROMSEL_EN
    check("no_df00", df00_cnt, 0);
`endif
    check("exp_wr_drained", exp_wr.size(), 0);
    check("exp_done_drained", exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
